lcd_cmd_sequencer: RTL and testbench
====================================

// Module: lcd_cmd_sequencer
// PURPOSE
//  Upstream command feeder for LCD_CTRL. Buffers host commands in a FIFO and issues them one at a time on
//  cmd/cmd_valid, only while LCD_CTRL busy is low. Stops after LCD_CTRL signals done for an issued WRITE (cmd 0).
//  Sits between the host/command source and LCD_CTRL, replacing the bench-level feeder.
// PARAMETERS
//  DEPTH  16  FIFO entries (power of 2, >=2)
//  CMD_W  4   command width, matches LCD_CTRL cmd
//  CNT_W  8   width of issued_cnt (saturating)
// PORTS
//  clk         input   1            rising-edge clock
//  reset       input   1            reset, asynchronous, active-low
//  host_cmd    input   CMD_W        command from host
//  host_valid  input   1            host_cmd valid
//  host_ready  output  1            FIFO can accept (comb: !full && !seq_done && reset)
//  busy        input   1            LCD_CTRL busy
//  done        input   1            LCD_CTRL done pulse
//  cmd         output  CMD_W        command to LCD_CTRL (registered)
//  cmd_valid   output  1            one-cycle issue strobe (registered)
//  fifo_count  output  clog2(DEPTH)+1  entries held
//  issued_cnt  output  CNT_W        commands issued, saturates at 2^CNT_W-1
//  seq_done    output  1            sticky: done observed, sequence finished
//  drop_err    output  1            sticky: host_valid while !host_ready (cmd discarded)
// BEHAVIOUR
//  Reset (reset==0, async): cmd=0, cmd_valid=0, FIFO empty, fifo_count=0, issued_cnt=0, seq_done=0, drop_err=0,
//   FSM=IDLE, host_ready=0. On release host_ready=1 the same cycle.
//  FIFO: push on host_valid&&host_ready at posedge. Push+pop in the same cycle -> count unchanged.
//   Pointers wrap mod DEPTH. Full -> host_ready=0. host_valid when !host_ready -> drop, drop_err=1.
//  FSM states IDLE, ISSUE, GUARD, WAIT, FINISH:
//   IDLE:   if !seq_done && !empty && !busy -> pop head, cmd<=head, cmd_valid<=1, issued_cnt++ -> ISSUE.
//           Empty or busy -> stay. Power-up busy (image load) holds issue.
//   ISSUE:  cmd_valid<=0 (strobe exactly 1 cycle), cmd holds value -> GUARD.
//   GUARD:  unconditional 1 cycle; covers LCD_CTRL raising busy one cycle after accept -> WAIT.
//   WAIT:   busy==0 -> IDLE, else stay.
//   FINISH: terminal until reset; cmd_valid=0, no pops.
//  Minimum issue spacing: 4 cycles (IDLE->ISSUE->GUARD->WAIT->IDLE) with busy never asserted.
//  done==1 in any state (incl. same cycle as an IDLE issue decision) -> seq_done<=1, FIFO flushed
//   (count=0), next state FINISH. An issue in that cycle is suppressed, and issued_cnt is not incremented.
//  Commands queued after WRITE are discarded by the flush. They are not reported in drop_err.
//  cmd holds its last value while cmd_valid=0. issued_cnt saturates; it never wraps.
//  Reset mid-operation: async clear per above. Any strobe in flight is dropped immediately.
// TESTING
//  T1 reset released, busy=1 for 70 cycles, push 3 cmds -> no cmd_valid until busy=0; then 3 one-cycle strobes
//     in FIFO order, issued_cnt=3.
//  T2 push DEPTH+1 cmds with busy held 1 -> host_ready=0 at count=16, 17th dropped, drop_err=1, fifo_count=16.
//  T3 busy never asserted, 5 cmds queued -> cmd_valid pulses exactly 4 cycles apart, cmd stable between pulses.
//  T4 queue {1,2,0,3}; model done 10 cycles after cmd 0 -> seq_done=1, fifo_count=0, cmd 3 never issued,
//     host_ready=0.
//  T5 simultaneous push and pop at count=5 -> fifo_count stays 5. Pointer wrap after 40 pushes keeps data order.
//  T6 reset asserted during GUARD with 4 queued -> all outputs return to reset values immediately.
//     After release with no pushes, no strobe occurs.

Source files
------------

// File: rtl/lcd_cmd_sequencer.sv
// Buffers host commands in a FIFO and issues them one at a time to LCD_CTRL while it is idle;
// the sequence terminates (FIFO flushed, issue stopped) when LCD_CTRL reports done.
module lcd_cmd_sequencer #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CMD_W = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [CMD_W-1:0]         host_cmd,
   input  logic                     host_valid,
   output logic                     host_ready,
   input  logic                     busy,
   input  logic                     done,
   output logic [CMD_W-1:0]         cmd,
   output logic                     cmd_valid,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [CNT_W-1:0]         issued_cnt,
   output logic                     seq_done,
   output logic                     drop_err
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_FW = PTR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_GUARD,
      S_WAIT,
      S_FINISH
   } state_t;

   state_t              state_q;
   logic [CMD_W-1:0]    mem_q [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q;
   logic [PTR_W-1:0]    rd_ptr_q;
   logic [CNT_FW-1:0]   count_q;
   logic [CMD_W-1:0]    cmd_q;
   logic                cmd_valid_q;
   logic [CNT_W-1:0]    issued_q;
   logic                seq_done_q;
   logic                drop_err_q;

   logic full_c;
   logic empty_c;
   logic push_c;
   logic pop_c;

   // Ready drops in reset so nothing is accepted until release, then rises the same cycle.
   assign full_c     = (count_q == CNT_FW'(DEPTH));
   assign empty_c    = (count_q == '0);
   assign host_ready = !full_c && !seq_done_q && reset;
   assign push_c     = host_valid && host_ready;
   assign pop_c      = (state_q == S_IDLE) && !seq_done_q && !empty_c && !busy && !done;

   // Storage array carries no reset; validity is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= host_cmd;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         cmd_q       <= '0;
         cmd_valid_q <= 1'b0;
         issued_q    <= '0;
         seq_done_q  <= 1'b0;
         drop_err_q  <= 1'b0;
      end else begin
         cmd_valid_q <= 1'b0;
         if (host_valid && !host_ready) begin
            drop_err_q <= 1'b1;
         end
         // Done wins over everything: flush, suppress any issue, and park in FINISH.
         if (done) begin
            seq_done_q <= 1'b1;
            state_q    <= S_FINISH;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
         end else begin
            if (push_c) begin
               wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
               rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_c && !pop_c) begin
               count_q <= count_q + CNT_FW'(1);
            end else if (pop_c && !push_c) begin
               count_q <= count_q - CNT_FW'(1);
            end
            case (state_q)
               S_IDLE: begin
                  if (pop_c) begin
                     cmd_q       <= mem_q[rd_ptr_q];
                     cmd_valid_q <= 1'b1;
                     if (issued_q != '1) begin
                        issued_q <= issued_q + CNT_W'(1);
                     end
                     state_q <= S_ISSUE;
                  end
               end
               S_ISSUE: state_q <= S_GUARD;
               // LCD_CTRL raises busy one cycle after accepting, so skip a cycle before sampling it.
               S_GUARD: state_q <= S_WAIT;
               S_WAIT: begin
                  if (!busy) begin
                     state_q <= S_IDLE;
                  end
               end
               default: state_q <= S_FINISH;
            endcase
         end
      end
   end

   assign cmd        = cmd_q;
   assign cmd_valid  = cmd_valid_q;
   assign fifo_count = count_q;
   assign issued_cnt = issued_q;
   assign seq_done   = seq_done_q;
   assign drop_err   = drop_err_q;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Scoreboard bench for lcd_cmd_sequencer: accepted host commands are queued as expected issues,
// a negedge monitor pops them against cmd_valid strobes and checks status outputs each cycle.
module tb_lcd_cmd_sequencer;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned CMD_W = 4;
   localparam int unsigned CNT_W = 8;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic [CMD_W-1:0]   host_cmd = '0;
   logic               host_valid = 1'b0;
   logic               host_ready;
   logic               busy = 1'b0;
   logic               done = 1'b0;
   logic [CMD_W-1:0]   cmd;
   logic               cmd_valid;
   logic [4:0]         fifo_count;
   logic [CNT_W-1:0]   issued_cnt;
   logic               seq_done;
   logic               drop_err;

   lcd_cmd_sequencer #(.DEPTH(DEPTH), .CMD_W(CMD_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .host_cmd(host_cmd), .host_valid(host_valid),
      .host_ready(host_ready), .busy(busy), .done(done), .cmd(cmd), .cmd_valid(cmd_valid),
      .fifo_count(fifo_count), .issued_cnt(issued_cnt), .seq_done(seq_done), .drop_err(drop_err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model state: commands accepted but not yet issued, plus sticky flags.
   int exp_q[$];
   bit m_done = 0;
   bit m_drop = 0;
   int m_issued = 0;
   int m_last_cmd = 0;
   int strobe_times[$];
   int strobe_cmds[$];
   bit s_push = 0, s_done = 0, s_drop = 0;
   int s_cmd = 0;
   bit prev_valid = 0, prev_busy = 0, prev_done = 0;
   int cyc = 0;
   int last_strobe = -100;
   bit auto_lcd = 0;

   task automatic check(input bit ok, input string name, input int act, input int exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Input snapshot taken mid-cycle; inputs are stable until the next rising edge.
   always @(negedge clk) begin
      s_push = host_valid && host_ready;
      s_cmd  = int'(host_cmd);
      s_done = done;
      s_drop = host_valid && !host_ready && reset;
   end

   // Model update at the edge where the DUT acts on the snapshot.
   always @(posedge clk) begin
      if (!reset) begin
         exp_q.delete();
         m_done = 0;
         m_drop = 0;
      end else begin
         if (s_done) begin
            exp_q.delete();
            m_done = 1;
         end else if (s_push) begin
            exp_q.push_back(s_cmd);
         end
         if (s_drop) m_drop = 1;
      end
   end

   // Monitor: compares strobes and status against the model every cycle.
   always @(negedge clk) begin
      int e;
      cyc++;
      if (!reset) begin
         check(cmd == '0, "rst_cmd", int'(cmd), 0);
         check(cmd_valid == 1'b0, "rst_cmd_valid", int'(cmd_valid), 0);
         check(fifo_count == '0, "rst_fifo_count", int'(fifo_count), 0);
         check(issued_cnt == '0, "rst_issued_cnt", int'(issued_cnt), 0);
         check(seq_done == 1'b0, "rst_seq_done", int'(seq_done), 0);
         check(drop_err == 1'b0, "rst_drop_err", int'(drop_err), 0);
         check(host_ready == 1'b0, "rst_host_ready", int'(host_ready), 0);
         m_issued = 0;
         m_last_cmd = 0;
         last_strobe = -100;
      end else begin
         if (cmd_valid) begin
            check(!prev_valid, "strobe_width", int'(prev_valid), 0);
            check(!prev_busy, "issue_while_busy", int'(prev_busy), 0);
            check(!prev_done, "issue_with_done", int'(prev_done), 0);
            check(cyc - last_strobe >= 4, "issue_spacing", cyc - last_strobe, 4);
            if (exp_q.size() == 0) begin
               check(0, "unexpected_strobe", int'(cmd), -1);
            end else begin
               e = exp_q.pop_front();
               check(int'(cmd) == e, "cmd_order", int'(cmd), e);
            end
            if (m_issued < (1 << CNT_W) - 1) m_issued++;
            m_last_cmd = int'(cmd);
            last_strobe = cyc;
            strobe_times.push_back(cyc);
            strobe_cmds.push_back(int'(cmd));
         end else begin
            check(int'(cmd) == m_last_cmd, "cmd_hold", int'(cmd), m_last_cmd);
         end
         check(int'(fifo_count) == exp_q.size(), "fifo_count", int'(fifo_count), exp_q.size());
         check(int'(issued_cnt) == m_issued, "issued_cnt", int'(issued_cnt), m_issued);
         check(seq_done == m_done, "seq_done", int'(seq_done), int'(m_done));
         check(drop_err == m_drop, "drop_err", int'(drop_err), int'(m_drop));
         e = (exp_q.size() < DEPTH && !m_done) ? 1 : 0;
         check(int'(host_ready) == e, "host_ready", int'(host_ready), e);
      end
      prev_valid = cmd_valid;
      prev_busy  = busy;
      prev_done  = done;
   end

   // LCD_CTRL stand-in: random busy after ordinary commands, long busy then done after WRITE (0).
   initial begin
      int b_cnt = 0;
      int wr_cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (auto_lcd) begin
            if (done) done = 1'b0;
            if (cmd_valid) begin
               if (cmd == '0) begin
                  wr_cnt = 10;
                  busy = 1'b1;
               end else begin
                  b_cnt = int'($urandom_range(0, 6));
                  busy = (b_cnt != 0);
               end
            end else if (wr_cnt > 0) begin
               wr_cnt--;
               if (wr_cnt == 0) begin
                  done = 1'b1;
                  busy = 1'b0;
               end
            end else if (b_cnt > 0) begin
               b_cnt--;
               busy = (b_cnt != 0);
            end
         end else begin
            b_cnt = 0;
            wr_cnt = 0;
         end
      end
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Push one command; optionally wait (bounded) for host_ready first.
   task automatic push(input int c, input bit wait_ready);
      int k = 0;
      while (wait_ready && !host_ready && k < 200) begin
         tick();
         k++;
      end
      if (wait_ready) check(k < 200, "push_ready_timeout", k, 200);
      host_valid = 1'b1;
      host_cmd = CMD_W'(c);
      tick();
      host_valid = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         tick();
         k++;
      end
      check(k < budget, "drain_timeout", exp_q.size(), 0);
      tick(8);
   endtask

   initial begin
      int k;
      #1 reset = 1'b0;
      tick(3);
      reset = 1'b1;
      #1 check(host_ready == 1'b1, "ready_on_release", int'(host_ready), 1);

      // T1: power-up busy holds issue; then three strobes in order
      busy = 1'b1;
      for (int i = 0; i < 3; i++) push(int'($urandom_range(1, 15)), 1'b1);
      tick(67);
      check(int'(issued_cnt) == 0, "t1_held_by_busy", int'(issued_cnt), 0);
      busy = 1'b0;
      tick(20);
      check(int'(issued_cnt) == 3, "t1_issued3", int'(issued_cnt), 3);

      // T2: overfill with busy held
      busy = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) push(int'($urandom_range(0, 15)) | 1, 1'b0);
      check(int'(fifo_count) == DEPTH, "t2_full_count", int'(fifo_count), DEPTH);
      check(host_ready == 1'b0, "t2_not_ready", int'(host_ready), 0);
      check(drop_err == 1'b1, "t2_drop_err", int'(drop_err), 1);
      busy = 1'b0;
      wait_drain(400);

      // T3: back-to-back issue with busy never asserted
      strobe_times.delete();
      for (int i = 0; i < 5; i++) push(int'($urandom_range(1, 15)), 1'b1);
      wait_drain(100);
      check(strobe_times.size() == 5, "t3_strobes", strobe_times.size(), 5);
      for (int i = 1; i < strobe_times.size(); i++)
         check(strobe_times[i] - strobe_times[i-1] == 4, "t3_gap",
               strobe_times[i] - strobe_times[i-1], 4);

      // T5: push and pop on the same edge, then pointer wrap
      busy = 1'b1;
      for (int i = 0; i < 5; i++) push(int'($urandom_range(1, 15)), 1'b1);
      busy = 1'b0;
      host_valid = 1'b1;
      host_cmd = CMD_W'($urandom_range(1, 15));
      tick();
      host_valid = 1'b0;
      check(int'(fifo_count) == 5, "t5_push_pop", int'(fifo_count), 5);
      for (int i = 0; i < 40; i++) push(int'($urandom_range(1, 15)), 1'b1);
      wait_drain(400);

      // Random traffic against a randomly busy LCD_CTRL
      auto_lcd = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 2) == 0) tick(int'($urandom_range(1, 6)));
         push(int'($urandom_range(1, 15)), 1'b1);
      end
      wait_drain(800);
      auto_lcd = 1'b0;
      busy = 1'b0;
      tick(2);

      // T6: reset during GUARD with four queued
      busy = 1'b1;
      for (int i = 0; i < 5; i++) push(int'($urandom_range(1, 15)), 1'b1);
      busy = 1'b0;
      k = 0;
      while (!cmd_valid && k < 50) begin
         tick();
         k++;
      end
      check(k < 50, "t6_strobe_timeout", k, 50);
      tick();
      reset = 1'b0;
      #1;
      check(cmd_valid == 1'b0, "t6_cmd_valid", int'(cmd_valid), 0);
      check(cmd == '0, "t6_cmd", int'(cmd), 0);
      check(fifo_count == '0, "t6_fifo_count", int'(fifo_count), 0);
      check(issued_cnt == '0, "t6_issued", int'(issued_cnt), 0);
      check(host_ready == 1'b0, "t6_host_ready", int'(host_ready), 0);
      tick(3);
      reset = 1'b1;
      strobe_times.delete();
      tick(20);
      check(strobe_times.size() == 0, "t6_no_strobe", strobe_times.size(), 0);

      // T4: {1,2,0,3}; done after WRITE terminates the sequence
      strobe_cmds.delete();
      auto_lcd = 1'b1;
      push(1, 1'b1);
      push(2, 1'b1);
      push(0, 1'b1);
      push(3, 1'b1);
      k = 0;
      while (!seq_done && k < 200) begin
         tick();
         k++;
      end
      check(k < 200, "t4_done_timeout", k, 200);
      tick(2);
      auto_lcd = 1'b0;
      done = 1'b0;
      busy = 1'b0;
      tick(10);
      check(seq_done == 1'b1, "t4_seq_done", int'(seq_done), 1);
      check(fifo_count == '0, "t4_flushed", int'(fifo_count), 0);
      check(host_ready == 1'b0, "t4_not_ready", int'(host_ready), 0);
      check(strobe_cmds.size() == 3, "t4_issue_count", strobe_cmds.size(), 3);
      if (strobe_cmds.size() > 0)
         check(strobe_cmds[strobe_cmds.size()-1] == 0, "t4_last_is_write",
               strobe_cmds[strobe_cmds.size()-1], 0);
      check(drop_err == 1'b0, "t4_flush_not_drop", int'(drop_err), 0);
      push(7, 1'b0);
      check(drop_err == 1'b1, "t4_drop_after_done", int'(drop_err), 1);

      // done on the same edge as an issue decision suppresses the issue
      reset = 1'b0;
      tick(3);
      reset = 1'b1;
      tick(2);
      push(5, 1'b0);
      done = 1'b1;
      tick();
      done = 1'b0;
      check(cmd_valid == 1'b0, "done_race_no_strobe", int'(cmd_valid), 0);
      check(issued_cnt == '0, "done_race_issued", int'(issued_cnt), 0);
      check(seq_done == 1'b1, "done_race_seq_done", int'(seq_done), 1);
      check(fifo_count == '0, "done_race_flush", int'(fifo_count), 0);
      tick(8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

endmodule
